// File: rtl/arb2_rr_reg_if.sv
// Valid/ready bundle for the two arbiter sources and the registered output.
interface arb2_rr_reg_if #(
    parameter int unsigned BW_DATA = 4
);
    logic               i_in0_valid;
    logic               o_in0_ready;
    logic [BW_DATA-1:0] i_in0;
    logic               i_in1_valid;
    logic               o_in1_ready;
    logic [BW_DATA-1:0] i_in1;
    logic               o_out_valid;
    logic               i_out_ready;
    logic [BW_DATA-1:0] o_out;
    logic               o_sel;

    // Arbiter side
    modport slave (
        input  i_in0_valid, i_in0, i_in1_valid, i_in1, i_out_ready,
        output o_in0_ready, o_in1_ready, o_out_valid, o_out, o_sel
    );

    // Environment side: sources and sink
    modport master (
        output i_in0_valid, i_in0, i_in1_valid, i_in1, i_out_ready,
        input  o_in0_ready, o_in1_ready, o_out_valid, o_out, o_sel
    );
endinterface

// File: rtl/arb2_rr_reg.sv
// Two-input round-robin arbiter feeding a one-entry registered output stage.
module arb2_rr_reg #(
    parameter int unsigned BW_DATA = 4
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    arb2_rr_reg_if.slave   bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               r_last;
    logic [BW_DATA-1:0] r_out;
    logic               r_sel;

    logic               load_en;
    logic               grant_valid;
    logic               grant;
    logic               accept;

    // Output stage can take a word when empty or when the sink drains it now
    assign load_en     = (state == EMPTY) || bus.i_out_ready;
    assign grant_valid = bus.i_in0_valid || bus.i_in1_valid;
    // Tie goes to the source not granted last; otherwise the lone requester
    assign grant       = (bus.i_in0_valid && bus.i_in1_valid) ? ~r_last : bus.i_in1_valid;
    assign accept      = load_en && grant_valid;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept fills, drain without refill empties, stall holds
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = FULL;
        end else if (load_en) begin
            state_nxt = EMPTY;
        end
    end

    // Data, select and fairness pointer update only on an accept
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_out  <= BW_DATA'(0);
            r_sel  <= 1'b0;
            r_last <= 1'b1;
        end else if (accept) begin
            r_out  <= grant ? bus.i_in1 : bus.i_in0;
            r_sel  <= grant;
            r_last <= grant;
        end
    end

    // Outputs: readies follow the grant; held during reset
    always_comb begin
        bus.o_in0_ready = 1'b0;
        bus.o_in1_ready = 1'b0;
        if (i_rstn && load_en) begin
            bus.o_in0_ready = (grant == 1'b0) && bus.i_in0_valid;
            bus.o_in1_ready = (grant == 1'b1) && bus.i_in1_valid;
        end
        bus.o_out_valid = (state == FULL);
        bus.o_out       = r_out;
        bus.o_sel       = r_sel;
    end
endmodule

// File: tb/tb_arb2_rr_reg.sv
// Directed self-checking bench for arb2_rr_reg.
module tb_arb2_rr_reg;
    localparam int unsigned BW_DATA = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    arb2_rr_reg_if #(.BW_DATA(BW_DATA)) bus ();

    arb2_rr_reg #(.BW_DATA(BW_DATA)) dut (
        .i_clk  (clk),
        .i_rstn (rst_n),
        .bus    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] d0,
                         input logic v1, input logic [3:0] d1, input logic rdy);
        bus.i_in0_valid = v0;
        bus.i_in0       = d0;
        bus.i_in1_valid = v1;
        bus.i_in1       = d1;
        bus.i_out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] d, input logic s);
        check({tag, "_valid"}, 32'(bus.o_out_valid), 32'(v));
        check({tag, "_out"},   32'(bus.o_out),       32'(d));
        check({tag, "_sel"},   32'(bus.o_sel),       32'(s));
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check({tag, "_rdy0"}, 32'(bus.o_in0_ready), 32'(r0));
        check({tag, "_rdy1"}, 32'(bus.o_in1_ready), 32'(r1));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // 1: reset with random inputs, before any clock edge
        rst_n = 1'b0;
        drive(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
        #1;
        check_out("rst", 1'b0, 4'h0, 1'b0);
        check_rdy("rst", 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;

        // 2: single in0 request
        drive(1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
        #1;
        check_rdy("single", 1'b1, 1'b0);
        tick();
        check_out("single", 1'b1, 4'hA, 1'b0);

        // fresh reset so the first tie goes to in0
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        // 3: both valid for 6 cycles alternates 0,1,0,1,0,1
        drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1);
        for (int i = 0; i < 6; i++) begin
            #1;
            check_rdy($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
            tick();
            check_out($sformatf("rr%0d", i), 1'b1, ((i % 2) == 0) ? 4'hA : 4'h5, 1'((i % 2) == 1));
        end

        // 4: load 3 from in0, then stall 4 cycles with both valid
        drive(1'b1, 4'h3, 1'b0, 4'h0, 1'b1);
        tick();
        check_out("load3", 1'b1, 4'h3, 1'b0);
        drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_rdy($sformatf("stall%0d", i), 1'b0, 1'b0);
            tick();
            check_out($sformatf("stall%0d", i), 1'b1, 4'h3, 1'b0);
        end
        bus.i_out_ready = 1'b1;
        #1;
        check_rdy("unstall", 1'b0, 1'b1);
        tick();
        check_out("unstall", 1'b1, 4'h5, 1'b1);

        // 5: grant in0, 3 idle cycles, then a tie goes to in1
        drive(1'b1, 4'hC, 1'b0, 4'h0, 1'b1);
        tick();
        check_out("g0", 1'b1, 4'hC, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("idle%0d", i), 1'b0, 4'hC, 1'b0);
        end
        drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1);
        #1;
        check_rdy("after_idle", 1'b0, 1'b1);
        tick();
        check_out("after_idle", 1'b1, 4'h5, 1'b1);

        // 6: async reset while FULL, then first tie goes to in0
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();
        check_out("full_hold", 1'b1, 4'h5, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 1'b0, 4'h0, 1'b0);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 4'hA, 1'b1, 4'h5, 1'b1);
        #1;
        check_rdy("post_rst", 1'b1, 1'b0);
        tick();
        check_out("post_rst", 1'b1, 4'hA, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
